// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory-port arbiter: FSM state encoding and the
// default byte-enable pattern used for fetches and loads.
package riscv_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_e;

  // Wide enough for any realistic DATA_W; users slice off the low DATA_W/8 bits.
  localparam int unsigned ARB_BE_MAX_W = 16;
  localparam logic [ARB_BE_MAX_W-1:0] ARB_BE_DEFAULT = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory-bus handshakes of the arbiter.
// master = arbiter view, slave = requesters plus memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_flush;
  logic                  if_ack;
  logic [DATA_W-1:0]     if_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  bus_req;
  logic                  bus_we;
  logic [DATA_W/8-1:0]   bus_be;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W-1:0]     bus_rdata;
  logic                  bus_ready;

  modport master (
    input  if_req, if_addr, if_flush,
    output if_ack, if_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    output if_req, if_addr, if_flush,
    input  if_ack, if_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/mem_port_arbiter_starve.sv
// Counts consecutive data grants that bypassed a waiting fetch; saturates at
// LIMIT so a flush-blocked fetch cannot push the count past the compare value.
module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  localparam int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [CNT_W-1:0] cnt;

  assign at_limit = (cnt == CNT_W'(LIMIT));

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && !at_limit)
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and MEM stage.
// Optional fetch anti-starvation guard: define ARB_STARVE_GUARD_EN.
//
//  state     | meaning
//  ----------+-------------------------------------------
//  ST_IDLE   | bus free, grant decision made this cycle
//  ST_FETCH  | bus owned by fetch, waiting for bus_ready
//  ST_DATA   | bus owned by MEM stage, waiting for bus_ready
module mem_port_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  p
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [BE_W-1:0] BE_ALL = ARB_BE_DEFAULT[BE_W-1:0];

  localparam logic [1:0] ST_IDLE  = ARB_IDLE;
  localparam logic [1:0] ST_FETCH = ARB_FETCH;
  localparam logic [1:0] ST_DATA  = ARB_DATA;

  logic [1:0]        state;
  logic              drop;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [BE_W-1:0]   bus_be_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;

  logic idle;
  logic busy_done;
  logic force_fetch;
  logic grant_data;
  logic grant_fetch;

  assign idle      = (state == ST_IDLE);
  assign busy_done = !idle && p.bus_ready;

`ifdef ARB_STARVE_GUARD_EN
  logic starve_hit;

  arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (grant_data && p.if_req && !p.if_flush),
    .clr      (grant_fetch || (idle && !p.if_req)),
    .at_limit (starve_hit)
  );

  assign force_fetch = starve_hit && p.mem_req && p.if_req && !p.if_flush;
`else
  assign force_fetch = 1'b0;
`endif

  assign grant_data  = idle && p.mem_req && !force_fetch;
  assign grant_fetch = idle && p.if_req && !p.if_flush && (!p.mem_req || force_fetch);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else if (grant_data) begin
      state       <= ST_DATA;
      bus_req_q   <= 1'b1;
      bus_we_q    <= p.mem_we;
      bus_be_q    <= p.mem_we ? p.mem_be : BE_ALL;
      bus_addr_q  <= p.mem_addr;
      bus_wdata_q <= p.mem_wdata;
    end else if (grant_fetch) begin
      state       <= ST_FETCH;
      bus_req_q   <= 1'b1;
      bus_we_q    <= 1'b0;
      bus_be_q    <= BE_ALL;
      bus_addr_q  <= p.if_addr;
      bus_wdata_q <= '0;
    end else if (busy_done) begin
      state     <= ST_IDLE;
      bus_req_q <= 1'b0;
    end
  end

  // The bus access always runs to completion; a flush only hides its ack.
  always_ff @(posedge clk) begin
    if (rst)
      drop <= 1'b0;
    else if (busy_done)
      drop <= 1'b0;
    else if ((state == ST_FETCH) && p.if_flush)
      drop <= 1'b1;
  end

  assign p.bus_req   = bus_req_q;
  assign p.bus_we    = bus_we_q;
  assign p.bus_be    = bus_be_q;
  assign p.bus_addr  = bus_addr_q;
  assign p.bus_wdata = bus_wdata_q;

  assign p.if_ack    = (state == ST_FETCH) && p.bus_ready && !drop && !p.if_flush;
  assign p.mem_ack   = (state == ST_DATA) && p.bus_ready;
  assign p.if_rdata  = p.if_ack  ? p.bus_rdata : '0;
  assign p.mem_rdata = p.mem_ack ? p.bus_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, collision, wait states, flush,
// reset mid-access and grant ordering under continuous requests.
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .p   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic quiet_inputs();
    bif.if_req    = 1'b0;
    bif.if_addr   = '0;
    bif.if_flush  = 1'b0;
    bif.mem_req   = 1'b0;
    bif.mem_we    = 1'b0;
    bif.mem_be    = '0;
    bif.mem_addr  = '0;
    bif.mem_wdata = '0;
    bif.bus_rdata = '0;
    bif.bus_ready = 1'b0;
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst = 1'b1;
    bif.bus_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (bif.bus_req !== 1'b0) begin failures++; $display("FAIL reset_bus_req got %b want 0", bif.bus_req); end
    checks++; if (bif.bus_we !== 1'b0) begin failures++; $display("FAIL reset_bus_we got %b want 0", bif.bus_we); end
    checks++; if (bif.bus_be !== 4'h0) begin failures++; $display("FAIL reset_bus_be got %h want 0", bif.bus_be); end
    checks++; if (bif.bus_addr !== 32'h0) begin failures++; $display("FAIL reset_bus_addr got %h want 0", bif.bus_addr); end
    checks++; if (bif.bus_wdata !== 32'h0) begin failures++; $display("FAIL reset_bus_wdata got %h want 0", bif.bus_wdata); end
    checks++; if ({bif.if_ack, bif.mem_ack} !== 2'b00) begin failures++; $display("FAIL reset_acks got %b want 00", {bif.if_ack, bif.mem_ack}); end
    checks++; if ((bif.if_rdata | bif.mem_rdata) !== 32'h0) begin failures++; $display("FAIL reset_rdata got %h/%h want 0", bif.if_rdata, bif.mem_rdata); end
    rst = 1'b0;
    bif.bus_ready = 1'b0;
  endtask

  task automatic test_ready_ignored_idle();
    @(negedge clk);
    bif.bus_ready = 1'b1;
    bif.bus_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if ({bif.if_ack, bif.mem_ack} !== 2'b00) begin failures++; $display("FAIL idle_ready_acks got %b want 00", {bif.if_ack, bif.mem_ack}); end
    checks++; if (bif.if_rdata !== 32'h0) begin failures++; $display("FAIL idle_ready_rdata got %h want 0", bif.if_rdata); end
    bif.bus_ready = 1'b0;
    bif.bus_rdata = '0;
  endtask

  task automatic test_fetch_only();
    @(negedge clk);
    bif.if_req  = 1'b1;
    bif.if_addr = 32'h100;
    @(negedge clk);
    bif.bus_ready = 1'b1;
    bif.bus_rdata = 32'h0000_0013;
    #1;
    checks++; if (bif.bus_req !== 1'b1) begin failures++; $display("FAIL fetch_bus_req got %b want 1", bif.bus_req); end
    checks++; if (bif.bus_addr !== 32'h100) begin failures++; $display("FAIL fetch_bus_addr got %h want 100", bif.bus_addr); end
    checks++; if ({bif.bus_we, bif.bus_be} !== 5'b0_1111) begin failures++; $display("FAIL fetch_we_be got %b want 01111", {bif.bus_we, bif.bus_be}); end
    checks++; if (bif.if_ack !== 1'b1) begin failures++; $display("FAIL fetch_if_ack got %b want 1", bif.if_ack); end
    checks++; if (bif.if_rdata !== 32'h13) begin failures++; $display("FAIL fetch_if_rdata got %h want 13", bif.if_rdata); end
    checks++; if (bif.mem_ack !== 1'b0) begin failures++; $display("FAIL fetch_mem_ack got %b want 0", bif.mem_ack); end
    @(negedge clk);
    bif.if_req    = 1'b0;
    bif.bus_ready = 1'b0;
    #1;
    checks++; if (bif.bus_req !== 1'b0) begin failures++; $display("FAIL fetch_idle_bus_req got %b want 0", bif.bus_req); end
    checks++; if (bif.if_ack !== 1'b0) begin failures++; $display("FAIL fetch_ack_pulse got %b want 0", bif.if_ack); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    bif.if_req   = 1'b1;
    bif.if_addr  = 32'h104;
    bif.mem_req  = 1'b1;
    bif.mem_we   = 1'b0;
    bif.mem_be   = 4'h1;
    bif.mem_addr = 32'h2000;
    @(negedge clk);
    bif.bus_ready = 1'b1;
    bif.bus_rdata = 32'hCAFE_0001;
    #1;
    checks++; if (bif.bus_addr !== 32'h2000) begin failures++; $display("FAIL coll_first_addr got %h want 2000", bif.bus_addr); end
    checks++; if (bif.bus_be !== 4'hF) begin failures++; $display("FAIL coll_load_be got %h want f", bif.bus_be); end
    checks++; if ({bif.mem_ack, bif.if_ack} !== 2'b10) begin failures++; $display("FAIL coll_first_acks got %b want 10", {bif.mem_ack, bif.if_ack}); end
    checks++; if (bif.mem_rdata !== 32'hCAFE_0001) begin failures++; $display("FAIL coll_mem_rdata got %h want cafe0001", bif.mem_rdata); end
    checks++; if (bif.if_rdata !== 32'h0) begin failures++; $display("FAIL coll_if_rdata_gated got %h want 0", bif.if_rdata); end
    @(negedge clk);
    bif.mem_req   = 1'b0;
    bif.bus_ready = 1'b0;
    #1;
    checks++; if (bif.bus_req !== 1'b0) begin failures++; $display("FAIL coll_gap_bus_req got %b want 0", bif.bus_req); end
    @(negedge clk);
    bif.bus_ready = 1'b1;
    bif.bus_rdata = 32'h0000_1234;
    #1;
    checks++; if (bif.bus_addr !== 32'h104) begin failures++; $display("FAIL coll_second_addr got %h want 104", bif.bus_addr); end
    checks++; if ({bif.mem_ack, bif.if_ack} !== 2'b01) begin failures++; $display("FAIL coll_second_acks got %b want 01", {bif.mem_ack, bif.if_ack}); end
    checks++; if (bif.if_rdata !== 32'h1234) begin failures++; $display("FAIL coll_if_rdata got %h want 1234", bif.if_rdata); end
    @(negedge clk);
    bif.if_req    = 1'b0;
    bif.bus_ready = 1'b0;
    bif.bus_rdata = '0;
  endtask

  task automatic test_store_wait_states();
    @(negedge clk);
    bif.mem_req   = 1'b1;
    bif.mem_we    = 1'b1;
    bif.mem_be    = 4'h3;
    bif.mem_addr  = 32'h2004;
    bif.mem_wdata = 32'h0000_BEEF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bif.bus_ready = (c == 4);
      #1;
      checks++; if ({bif.bus_req, bif.bus_we, bif.bus_be} !== 6'b11_0011) begin failures++; $display("FAIL store_ctrl_c%0d got %b want 110011", c, {bif.bus_req, bif.bus_we, bif.bus_be}); end
      checks++; if ({bif.bus_addr, bif.bus_wdata} !== {32'h2004, 32'h0000_BEEF}) begin failures++; $display("FAIL store_addr_data_c%0d got %h/%h want 2004/0000beef", c, bif.bus_addr, bif.bus_wdata); end
      checks++; if (bif.mem_ack !== (c == 4)) begin failures++; $display("FAIL store_ack_c%0d got %b want %b", c, bif.mem_ack, (c == 4)); end
    end
    checks++; if (bif.mem_rdata !== 32'h0) begin failures++; $display("FAIL store_mem_rdata got %h want 0", bif.mem_rdata); end
    @(negedge clk);
    bif.mem_req   = 1'b0;
    bif.mem_we    = 1'b0;
    bif.bus_ready = 1'b0;
  endtask

  task automatic test_flush();
    @(negedge clk);
    bif.if_req  = 1'b1;
    bif.if_addr = 32'h108;
    @(negedge clk);
    bif.if_flush = 1'b1;
    #1;
    checks++; if ({bif.bus_req, bif.if_ack} !== 2'b10) begin failures++; $display("FAIL flush_inflight got %b want 10", {bif.bus_req, bif.if_ack}); end
    @(negedge clk);
    bif.if_flush  = 1'b0;
    bif.if_addr   = 32'h200;
    bif.bus_ready = 1'b1;
    bif.bus_rdata = 32'h0000_0777;
    #1;
    checks++; if (bif.if_ack !== 1'b0) begin failures++; $display("FAIL flush_dropped_ack got %b want 0", bif.if_ack); end
    checks++; if (bif.if_rdata !== 32'h0) begin failures++; $display("FAIL flush_dropped_rdata got %h want 0", bif.if_rdata); end
    @(negedge clk);
    bif.bus_ready = 1'b0;
    #1;
    checks++; if (bif.bus_req !== 1'b0) begin failures++; $display("FAIL flush_idle got %b want 0", bif.bus_req); end
    @(negedge clk);
    bif.bus_ready = 1'b1;
    bif.bus_rdata = 32'h0000_0055;
    #1;
    checks++; if (bif.bus_addr !== 32'h200) begin failures++; $display("FAIL flush_new_pc got %h want 200", bif.bus_addr); end
    checks++; if ({bif.if_ack, bif.if_rdata} !== {1'b1, 32'h55}) begin failures++; $display("FAIL flush_new_ack got %b/%h want 1/55", bif.if_ack, bif.if_rdata); end
    // Flush while idle holds off the grant for exactly that cycle.
    @(negedge clk);
    bif.bus_ready = 1'b0;
    bif.if_addr   = 32'h300;
    bif.if_flush  = 1'b1;
    @(negedge clk);
    bif.if_flush = 1'b0;
    #1;
    checks++; if (bif.bus_req !== 1'b0) begin failures++; $display("FAIL idle_flush_block got %b want 0", bif.bus_req); end
    @(negedge clk);
    bif.bus_ready = 1'b1;
    #1;
    checks++; if ({bif.bus_req, bif.bus_addr, bif.if_ack} !== {1'b1, 32'h300, 1'b1}) begin failures++; $display("FAIL idle_flush_regrant got %b/%h/%b want 1/300/1", bif.bus_req, bif.bus_addr, bif.if_ack); end
    @(negedge clk);
    bif.if_req    = 1'b0;
    bif.bus_ready = 1'b0;
    bif.bus_rdata = '0;
  endtask

  task automatic test_reset_mid_data();
    @(negedge clk);
    bif.mem_req  = 1'b1;
    bif.mem_we   = 1'b1;
    bif.mem_be   = 4'hC;
    bif.mem_addr = 32'h3000;
    bif.mem_wdata = 32'h1111_2222;
    @(negedge clk);
    #1;
    checks++; if (bif.bus_req !== 1'b1) begin failures++; $display("FAIL rstmid_started got %b want 1", bif.bus_req); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bif.bus_ready = 1'b1;
    bif.bus_rdata = 32'hAAAA_5555;
    #1;
    checks++; if ({bif.bus_req, bif.bus_we, bif.bus_be} !== 6'b0) begin failures++; $display("FAIL rstmid_ctrl got %b want 000000", {bif.bus_req, bif.bus_we, bif.bus_be}); end
    checks++; if ({bif.bus_addr, bif.bus_wdata} !== 64'h0) begin failures++; $display("FAIL rstmid_addr_data got %h/%h want 0/0", bif.bus_addr, bif.bus_wdata); end
    checks++; if ({bif.mem_ack, bif.if_ack, bif.mem_rdata} !== 34'h0) begin failures++; $display("FAIL rstmid_acks got %b/%b/%h want 0/0/0", bif.mem_ack, bif.if_ack, bif.mem_rdata); end
    bif.mem_req   = 1'b0;
    bif.mem_we    = 1'b0;
    bif.bus_ready = 1'b0;
    bif.bus_rdata = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_fetch;
`ifdef ARB_STARVE_GUARD_EN
    exp_fetch = 6'b010000;
`else
    exp_fetch = 6'b000000;
`endif
    @(negedge clk);
    bif.if_req    = 1'b1;
    bif.if_addr   = 32'h400;
    bif.mem_req   = 1'b1;
    bif.mem_we    = 1'b0;
    bif.mem_addr  = 32'h4000;
    bif.bus_ready = 1'b1;
    bif.bus_rdata = 32'h0000_0042;
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      #1;
      checks++; if ({bif.if_ack, bif.mem_ack} !== {exp_fetch[g], ~exp_fetch[g]}) begin failures++; $display("FAIL grant_seq_%0d got if/mem %b want %b", g, {bif.if_ack, bif.mem_ack}, {exp_fetch[g], ~exp_fetch[g]}); end
      @(negedge clk);
    end
    bif.if_req    = 1'b0;
    bif.mem_req   = 1'b0;
    bif.bus_ready = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    quiet_inputs();
    test_reset();
    test_ready_ignored_idle();
    test_fetch_only();
    test_collision();
    test_store_wait_states();
    test_flush();
    test_reset_mid_data();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0t want completion", $time);
    $fatal(1, "bench did not complete");
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch path and the MEM-stage load/store path of the five-stage core. Each requester uses a hold-until-ack handshake. The block grants one requester at a time, registers the winning request onto the bus, and returns the bus response to the granted side. Data accesses take priority, and a branch flush can cancel delivery of an in-flight fetch.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8 bits)
- STARVE_LIMIT, 4, consecutive data grants before a forced fetch grant (used only with the macro)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address (PC)
- if_flush  in  1  branch redirect; drops delivery of any pending or in-flight fetch
- if_ack  out  1  fetch complete; 1-cycle pulse
- if_rdata  out  DATA_W  instruction word; valid when if_ack, else 0
- mem_req  in  1  data request, held until mem_ack
- mem_we  in  1  1 = store
- mem_be  in  DATA_W/8  store byte enables
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_ack  out  1  data access complete; 1-cycle pulse
- mem_rdata  out  DATA_W  load data; valid when mem_ack, else 0
- bus_req  out  1  memory request, held until bus_ready
- bus_we  out  1  write strobe
- bus_be  out  DATA_W/8  byte enables; all ones for fetches and loads
- bus_addr  out  ADDR_W  address
- bus_wdata  out  DATA_W  write data
- bus_rdata  in  DATA_W  read data, valid with bus_ready
- bus_ready  in  1  transaction done; may assert in the first cycle bus_req is high

## Operation
- FSM states:
  - IDLE
  - FETCH: bus owned by fetch
  - DATA: bus owned by MEM
- In IDLE:
  - If mem_req is high, latch the mem_* signals onto the bus_* registers and go to DATA.
  - Else if if_req is high and if_flush is low, latch if_addr (we=0, be=all ones, wdata=0) and go to FETCH.
  - Else stay in IDLE.
- In FETCH or DATA: bus_* outputs are held constant. When bus_ready is high, return to IDLE.
- Acknowledge generation is combinational:
  - if_ack = (state==FETCH) & bus_ready & ~drop & ~if_flush
  - mem_ack = (state==DATA) & bus_ready
  - rdata is passed through from bus_rdata, gated by the corresponding ack.
- drop flag:
  - Set when if_flush is high while in FETCH.
  - Cleared on the return to IDLE.
  - The in-flight bus transaction is never aborted; only its ack is suppressed.
- if_flush in IDLE blocks a fetch grant in that cycle. The requester presents the new PC on the following cycle.
- Simultaneous if_req and mem_req in IDLE: DATA wins. The fetch waits.
- Reset values:
  - state IDLE, drop 0, starve counter 0
  - bus_req 0, bus_we 0, bus_be 0, bus_addr 0, bus_wdata 0
  - if_ack 0, mem_ack 0, both rdata outputs 0
- rst during a transaction forces bus_req low on the next edge. The memory shares rst and abandons the access.

## Timing
- Grant decision is made in IDLE at edge N. bus_req is high from cycle N+1.
- Ack is asserted in the same cycle as bus_ready. The FSM is in IDLE the following cycle.
- Minimum 2 cycles per access, with zero-wait memory. Back-to-back throughput is 1 access per 2 cycles.
- Requesters may change req/payload in the cycle after ack. IDLE samples them then, so there is no double grant.
- bus_ready outside FETCH/DATA is ignored.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A counter increments on each DATA grant made while if_req is high and if_flush is low.
  - It clears on any FETCH grant, or when if_req is low in IDLE.
  - When the count equals STARVE_LIMIT and both requests are present, FETCH is granted instead.
- Undefined: strict data priority. The counter is not instantiated.

## Structure
- Shared package riscv_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_FETCH, ARB_DATA)
  - the default byte-enable constant
- Natural sub-module: arb_starve_counter, instantiated only under ARB_STARVE_GUARD_EN. The FSM, bus registers and ack logic stay in the top module.

## Test plan
- Fetch only, zero-wait memory: if_req with if_addr=0x100, bus_rdata=0x00000013 -> bus_req/bus_addr=0x100 in cycle 1, if_ack and if_rdata=0x13 in cycle 1, state IDLE in cycle 2.
- Collision: if_req (0x104) and mem_req load (0x2000) in the same cycle -> 0x2000 served first, mem_ack, then 0x104 granted 1 cycle later.
- Store with 3 wait states: mem_we=1, be=0x3, addr=0x2004, wdata=0xBEEF -> bus signals held stable for 4 cycles, mem_ack on the 4th, mem_rdata=0.
- Flush in flight: fetch to 0x108 granted, if_flush pulses 1 cycle before bus_ready -> no if_ack for 0x108. A new if_addr=0x200 is granted in the next IDLE.
- Reset mid-DATA: rst asserted in cycle 2 of a 5-cycle access -> next cycle bus_req=0, all outputs at reset values, no ack.
- With ARB_STARVE_GUARD_EN and STARVE_LIMIT=4: continuous mem_req plus if_req -> grant sequence D,D,D,D,F,D...; without the macro -> D only.
